mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multi-cycle data-memory controller between the MEM pipeline stage and an external single-port synchronous-read SRAM.
- Accepts one read or write request per access, sequences SRAM strobes for a fixed number of wait states, returns read data, and raises a stall so the pipeline freezes until the access completes.
- Replaces the single-cycle data memory in the MEM stage.

Parameters:
- BIT_NUMBER, 32, data/address width of the pipeline side.
- ADDR_W, 16, SRAM word-address width.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- WAIT_STATES, 5, extra SRAM cycles per access beyond the first (0..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- mem_r_en  in  1  read request from MEM stage
- mem_w_en  in  1  write request from MEM stage
- addr  in  BIT_NUMBER  byte address (ALU result)
- wdata  in  BIT_NUMBER  store data (Rm value)
- rdata  out  BIT_NUMBER  registered load data
- ready  out  1  access complete / no access pending
- stall  out  1  freeze pipeline; = (mem_r_en | mem_w_en) & ~ready
- sram_addr  out  ADDR_W  SRAM word address
- sram_wdata  out  BIT_NUMBER  SRAM write data
- sram_we_n  out  1  SRAM write strobe, active-low
- sram_oe_n  out  1  SRAM output enable, active-low
- sram_rdata  in  BIT_NUMBER  SRAM read data

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, cnt=0, rdata=0, sram_addr=0, sram_wdata=0, sram_we_n=1, sram_oe_n=1. Takes effect immediately mid-access; the in-flight access is abandoned and nothing is retried.
- Address translation: sram_addr = ((addr - BASE_ADDR) >> 2) truncated to ADDR_W. Low two bits are ignored; no range check.
- States: IDLE, ACCESS, DONE.
- IDLE: ready = ~(mem_r_en | mem_w_en). On a request, latch sram_addr, sram_wdata and the operation, load cnt=WAIT_STATES, go to ACCESS.
- ACCESS:
  - Read: sram_oe_n=0.
  - Write: sram_we_n=0. Strobes are registered and stable for the entire state.
  - cnt decrements each cycle. When cnt==0, a read captures sram_rdata into rdata, strobes return high on the next edge, and the state goes to DONE.
- DONE: ready=1 for exactly one cycle (stall=0, pipeline advances), then IDLE unconditionally.
- Latency: request first seen in cycle 0; ACCESS spans cycles 1..WAIT_STATES+1; ready in cycle WAIT_STATES+2. Stall is high for WAIT_STATES+2 cycles.
- Back-to-back requests: a new request seen in the IDLE cycle after DONE starts immediately. There are no dead cycles beyond IDLE.
- mem_r_en and mem_w_en both high: treated as a read; sram_we_n stays high.
- Request inputs are assumed held stable while stall=1. Changes during ACCESS are ignored because the values latched on entry are used.
- rdata holds its value until the next read completes; writes do not alter it.

Optional Feature:
- Macro WRITE_BUFFER_EN.
- Defined: a one-entry posted write buffer is added.
  - A write seen in IDLE with the buffer empty is captured, ready=1 in that same cycle (stall=0), and the buffer drains through ACCESS in the background. The background drain does not pass through DONE with ready; it returns to IDLE.
  - Any request arriving while a drain is in progress stalls until the drain finishes, then is serviced normally.
  - Reset clears the buffer.
- Undefined: writes stall exactly like reads.

Test Plan:
- Reset: hold rst=0 with random inputs -> rdata=0, sram_we_n=1, sram_oe_n=1, state IDLE, stall=0 with no request.
- Read, WAIT_STATES=5: mem_r_en=1, addr=1028, sram_rdata=0xDEADBEEF -> sram_addr=1, sram_oe_n=0 for 6 cycles, stall=1 for cycles 0..6, ready=1 in cycle 7, rdata=0xDEADBEEF.
- Write: mem_w_en=1, addr=1032, wdata=0x12345678 -> sram_addr=2, sram_we_n=0 for 6 cycles, sram_wdata=0x12345678, ready in cycle 7, rdata unchanged.
- Back-to-back: write to 1024 then read from 1024, with the SRAM model returning the stored word -> rdata=written value; second access begins in the IDLE cycle after DONE.
- Reset mid-access: rst=0 in the third ACCESS cycle -> strobes high immediately; after release, state IDLE and no access resumes.
- WRITE_BUFFER_EN: write to 1024 then read in the next cycle -> write stall=0; read stalls until the drain completes plus 7 cycles and returns the written data.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - multi-cycle SRAM data-memory controller for the MEM stage
// Optional one-entry posted write buffer: define WRITE_BUFFER_EN.
module mem_access_ctrl #(
  parameter int BIT_NUMBER  = 32,
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [BIT_NUMBER-1:0] addr,
  input  logic [BIT_NUMBER-1:0] wdata,
  output logic [BIT_NUMBER-1:0] rdata,
  output logic                  ready,
  output logic                  stall,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [BIT_NUMBER-1:0] sram_wdata,
  output logic                  sram_we_n,
  output logic                  sram_oe_n,
  input  logic [BIT_NUMBER-1:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    req;
  logic                    drain;
  logic                    idle_ready;
  logic [BIT_NUMBER-1:0]   byte_off;
  logic [ADDR_W-1:0]       word_addr;

  assign req       = mem_r_en | mem_w_en;
  assign byte_off  = addr - BIT_NUMBER'(BASE_ADDR);
  assign word_addr = ADDR_W'(byte_off >> 2);

`ifdef WRITE_BUFFER_EN
  // A pure write is posted from IDLE and drained in the background.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drain <= 1'b0;
    else if (state == IDLE && req)
      drain <= ~mem_r_en;
  end
  assign idle_ready = ~mem_r_en;
`else
  assign drain      = 1'b0;
  assign idle_ready = ~req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = drain ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = idle_ready;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign stall = req & ~ready;

  // Strobes are registered so they stay glitch-free across the whole ACCESS window;
  // a low output enable also marks the latched operation as a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 4'd0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            sram_addr  <= word_addr;
            sram_wdata <= wdata;
            cnt        <= 4'(WAIT_STATES);
            sram_oe_n  <= ~mem_r_en;
            sram_we_n  <= mem_r_en;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!sram_oe_n)
              rdata <= sram_rdata;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with randomized accesses
module tb_mem_access_ctrl;
  localparam int BN   = 32;
  localparam int AW   = 16;
  localparam int BASE = 1024;
  localparam int WS   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_r_en, mem_w_en;
  logic [BN-1:0] addr, wdata, rdata, sram_wdata, sram_rdata;
  logic          ready, stall;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n, sram_oe_n;

  always #5 clk = ~clk;

  mem_access_ctrl #(.BIT_NUMBER(BN), .ADDR_W(AW), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .stall(stall), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_rdata(sram_rdata)
  );

  typedef struct {
    bit          is_read;
    logic [15:0] word;
    logic [31:0] data;
    int          exp_stall;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          drain_free = 0;
  logic [31:0] sram_mem [int];
  logic [31:0] ref_mem  [int];

  function automatic logic [31:0] init_word(int w);
    return {16'hC0DE, 16'(w)};
  endfunction

  function automatic int ref_word(logic [31:0] a);
    logic [31:0] d;
    d = a - 32'(BASE);
    return int'((d / 4) % 65536);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // External synchronous-read SRAM
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[int'(sram_addr)] = sram_wdata;
    if (!sram_oe_n)
      sram_rdata <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : init_word(int'(sram_addr));
  end

  // Monitor: accumulates stall/strobe cycles and pops one expectation per completed request
  int          st_cnt = 0, oe_cnt = 0, we_cnt = 0;
  logic [31:0] last_rd = 32'h0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      st_cnt = 0; oe_cnt = 0; we_cnt = 0; last_rd = 32'h0;
    end else begin
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
`ifndef WRITE_BUFFER_EN
      if (sb.size() > 0 && (!sram_oe_n || !sram_we_n)) begin
        check("sram_addr", 32'(sram_addr), 32'(sb[0].word));
        if (!sram_we_n) check("sram_wdata", sram_wdata, sb[0].data);
      end
`endif
      if (mem_r_en || mem_w_en) begin
        if (stall) st_cnt++;
        else begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_completion actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("stall_cycles", 32'(st_cnt), 32'(e.exp_stall));
            if (e.is_read) begin
              check("rdata", rdata, e.data);
              last_rd = e.data;
            end else begin
              check("rdata_hold", rdata, last_rd);
            end
`ifndef WRITE_BUFFER_EN
            check("oe_cycles", 32'(oe_cnt), e.is_read ? 32'(WS + 1) : 32'd0);
            check("we_cycles", 32'(we_cnt), e.is_read ? 32'd0 : 32'(WS + 1));
`endif
          end
          st_cnt = 0; oe_cnt = 0; we_cnt = 0;
        end
      end
    end
  end

  // Drive one request (called just after a rising edge) and hold it until stall drops
  task automatic issue(input bit rd, input bit both, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   w, n;
    int   start;
    w = ref_word(a);
    e.is_read = rd;
    e.word    = 16'(w);
    if (rd) e.data = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    else begin e.data = d; ref_mem[w] = d; end
    start = (cyc < drain_free) ? drain_free : cyc;
`ifdef WRITE_BUFFER_EN
    if (rd) e.exp_stall = start - cyc + WS + 2;
    else begin e.exp_stall = start - cyc; drain_free = start + WS + 2; end
`else
    e.exp_stall = WS + 2;
`endif
    sb.push_back(e);
    mem_r_en = rd; mem_w_en = !rd || both; addr = a; wdata = d;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!stall) break;
    end
    if (n == 200) begin
      n_tests++; n_fail++;
      $display("FAIL timeout actual=stalled required=complete (cycle %0d)", cyc);
    end
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic idle_cycles(input int g);
    repeat (g) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0; sram_rdata = '0;
    // Reset with random request inputs
    repeat (3) begin
      @(posedge clk); #1;
      mem_r_en = 1'($urandom); mem_w_en = 1'($urandom); addr = $urandom; wdata = $urandom;
      @(negedge clk);
      check("rst_rdata", rdata, 32'h0);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    end
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Directed accesses
    sram_mem[1] = 32'hDEADBEEF; ref_mem[1] = 32'hDEADBEEF;
    issue(1'b1, 1'b0, 32'd1028, 32'h0);
    issue(1'b0, 1'b0, 32'd1032, 32'h12345678);
    issue(1'b0, 1'b0, 32'd1024, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 32'd1024, 32'h0);
    issue(1'b1, 1'b1, 32'd1033, 32'h55AA55AA);
    idle_cycles(12);

    // Reset during the third ACCESS cycle of a read
    mem_r_en = 1'b1; addr = 32'd1028;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_oe_n", 32'(sram_oe_n), 32'd1);
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_rdata", rdata, 32'h0);
    mem_r_en = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    drain_free = 0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_oe_n", 32'(sram_oe_n), 32'd1);
      check("post_rst_ready", 32'(ready), 32'd1);
    end
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'(BASE) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      issue(1'($urandom), 1'($urandom_range(0, 5) == 0), a, $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(WS + 6);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
